// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 16x16 unsigned shift-add multiply sequencer driving a shared ALU.
// Produces the low 16 bits of the product plus a sticky overflow flag.
module alu_mul_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] mcand,
   input  logic [15:0] mplier,
   output logic        busy,
   output logic        done,
   output logic [15:0] product,
   output logic        ovfl,
   output logic [3:0]  alu_op,
   output logic [15:0] alu_in1,
   output logic [15:0] alu_in2,
   input  logic [15:0] alu_out
);
   typedef enum logic [1:0] {IDLE, ADD, SHL, DONE} state_t;
   state_t state, state_n;
   logic [15:0] acc, mc, mp, mp_sh;

   assign mp_sh   = mp >> 1;
   assign busy    = state != IDLE;
   assign done    = state == DONE;
   assign product = acc;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;

   always_comb begin
      state_n = state;
      alu_op  = state == SHL ? 4'b0100 : 4'b0000;
      alu_in1 = state == ADD ? acc : state == SHL ? mc : 16'h0000;
      alu_in2 = state == ADD ? mc : state == SHL ? 16'h0001 : 16'h0000;
      case (state)
         IDLE: if (start) state_n = mplier == 16'h0000 ? DONE : mplier[0] ? ADD : SHL;
         ADD:  state_n = SHL;
         SHL:  state_n = mp_sh == 16'h0000 ? DONE : mp[1] ? ADD : SHL;
         default: state_n = IDLE;
      endcase
   end

   // Overflow is sticky: a carry out of the add, or a set bit shifted out while multiplier bits remain.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc  <= '0;
         mc   <= '0;
         mp   <= '0;
         ovfl <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               acc  <= '0;
               mc   <= mcand;
               mp   <= mplier;
               ovfl <= 1'b0;
            end
            ADD: begin
               acc <= alu_out;
               if (alu_out < acc) ovfl <= 1'b1;
            end
            SHL: begin
               mc <= alu_out;
               mp <= mp_sh;
               if (mc[15] && mp_sh != 16'h0000) ovfl <= 1'b1;
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed-vector bench for alu_mul_seq with a behavioural ALU.
module tb_alu_mul_seq;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [15:0] mcand = '0, mplier = '0;
   logic busy, done, ovfl;
   logic [15:0] product, alu_in1, alu_in2, alu_out;
   logic [3:0] alu_op;
   int n_cmp = 0, n_bad = 0, bad_in2 = 0;
   logic [63:0] tr;

   alu_mul_seq dut (
      .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
      .busy(busy), .done(done), .product(product), .ovfl(ovfl),
      .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out)
   );

   assign alu_out = alu_op == 4'b0000 ? alu_in1 + alu_in2 :
                    alu_op == 4'b0100 ? alu_in1 << alu_in2[3:0] : 16'h0000;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Start at cycle 0; cycle n is sampled on the falling edge n clocks after acceptance.
   task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] ep, input logic eo, input int ec, input bit ign);
      int dc;
      logic [15:0] p;
      logic o;
      dc = 0; p = '0; o = 1'b0; tr = '0;
      @(negedge clk);
      mcand = a; mplier = b; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 1; n <= 40 && dc == 0; n++) begin
         @(negedge clk);
         if (done) begin
            dc = n; p = product; o = ovfl;
         end else if (busy) begin
            tr[n-1] = alu_op == 4'b0100;
            if (alu_op == 4'b0100 && alu_in2 != 16'h0001) bad_in2++;
         end
         start = ign && (n == 2 || n == 5);
      end
      start = 1'b0;
      chk({tag, " done_cycle"}, 64'(dc), 64'(ec));
      chk({tag, " product"}, 64'(p), 64'(ep));
      chk({tag, " ovfl"}, 64'(o), 64'(eo));
      @(negedge clk);
      chk({tag, " busy_after"}, 64'(busy), 64'd0);
      if (ign) begin
         @(negedge clk);
         chk({tag, " no_restart"}, {62'd0, busy, done}, 64'd0);
      end
   endtask

   initial begin
      #2;
      chk("reset_outputs", {busy, done, product, ovfl, alu_op, alu_in1, alu_in2}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run("m3x5", 16'd3, 16'd5, 16'h000F, 1'b0, 6, 1'b0);
      chk("m3x5 op_trace", tr, 64'h16);
      run("mplier0", 16'h1234, 16'h0000, 16'h0000, 1'b0, 1, 1'b0);
      chk("mplier0 op_trace", tr, 64'h0);
      run("shift_out", 16'h0100, 16'h0100, 16'h0000, 1'b1, 11, 1'b0);
      run("carry", 16'hFFFF, 16'h0003, 16'hFFFD, 1'b1, 5, 1'b0);
      run("worst", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 33, 1'b0);
      run("small", 16'd7, 16'd6, 16'd42, 1'b0, 6, 1'b0);
      run("ignore", 16'd3, 16'd5, 16'h000F, 1'b0, 6, 1'b1);
      chk("shl_in2", 64'(bad_in2), 64'd0);

      @(negedge clk);
      mcand = 16'hFFFF; mplier = 16'hFFFF; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (6) @(negedge clk);
      chk("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("async_reset", {busy, done, product, ovfl, alu_op, alu_in1, alu_in2}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset", {busy, done, alu_op, alu_in1, alu_in2}, 64'd0);
      run("after_rst", 16'd9, 16'd2, 16'd18, 1'b0, 4, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
